// File: rtl/regfile_loader_if.sv
// regfile_loader_if: byte stream and register-file port bundle for regfile_loader
//   in_data/in_valid/in_ready             valid/ready byte stream into the loader
//   instr_code/writedata/regwrite/RsCont  register file controls driven by the loader
//   readdata                              combinational read data returned by the register file
//   master = loader side, slave = stream source / register file side
interface regfile_loader_if #(parameter int DW = 8);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    instr_code;
    logic [DW-1:0] writedata;
    logic          regwrite;
    logic          RsCont;
    logic [DW-1:0] readdata;
    modport master (
        input  in_data, in_valid, readdata,
        output in_ready, instr_code, writedata, regwrite, RsCont
    );
    modport slave (
        output in_data, in_valid, readdata,
        input  in_ready, instr_code, writedata, regwrite, RsCont
    );
endinterface

// File: rtl/regfile_loader.sv
// regfile_loader: loads registers 0..NREG-1 from a byte stream, verifying each by readback
//   clk      single rising-edge clock
//   reset    synchronous, active-low reset
//   start    begin a load (honoured only in IDLE, DONE or ERR)
//   bus      stream + register file port (master side)
//   busy     high in LOAD, WRITE and CHECK
//   done     all NREG registers written and verified
//   error    readback mismatch; err_idx holds the failing register index
//   NREG must be in 1..8 because the index is 3 bits wide.
module regfile_loader #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    regfile_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_idx
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;
    localparam logic [2:0] LAST = 3'(NREG - 1);
    state_t        state, state_n;
    logic [2:0]    idx, idx_n, err_idx_n;
    logic [DW-1:0] hold, hold_n;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            hold    <= '0;
            err_idx <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            hold    <= hold_n;
            err_idx <= err_idx_n;
        end
    end
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        hold_n    = hold;
        err_idx_n = err_idx;
        case (state)
            IDLE, DONE, ERR: if (start) begin
                state_n   = LOAD;
                idx_n     = '0;
                err_idx_n = '0;
            end
            LOAD: if (bus.in_valid) begin
                hold_n  = bus.in_data;
                state_n = WRITE;
            end
            WRITE: state_n = CHECK;
            CHECK: if (bus.readdata != hold) begin
                state_n   = ERR;
                err_idx_n = idx;
            end else if (idx == LAST) begin
                state_n = DONE;
            end else begin
                idx_n   = idx + 3'd1;
                state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end
    assign busy           = state inside {LOAD, WRITE, CHECK};
    assign done           = state == DONE;
    assign error          = state == ERR;
    assign bus.in_ready   = state == LOAD;
    assign bus.regwrite   = state == WRITE;
    assign bus.RsCont     = busy;
    // writedata is hold itself, so it already carries the last captured byte outside WRITE
    assign bus.writedata  = hold;
    // both register fields carry idx so write and readback target the same register
    assign bus.instr_code = state == IDLE ? 8'h00 : {2'b00, idx, idx};
endmodule

// File: tb/tb_regfile_loader.sv
// tb_regfile_loader: randomized self-checking bench for regfile_loader
module tb_regfile_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;
    logic [2:0] err_idx;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    logic prev_rw = 1'b0;
    logic done_at_start;
    logic fault_en = 1'b0;
    logic [2:0] fault_idx = 3'd0;
    logic [7:0] rf [8];
    logic [15:0] wq [$];
    logic [7:0] d [8];
    int st [8];

    regfile_loader_if #(.DW(8)) bus();

    regfile_loader #(.NREG(8), .DW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.regwrite === 1'b1) rf[bus.instr_code[2:0]] <= bus.writedata;

    assign bus.readdata = (fault_en && bus.instr_code[5:3] == fault_idx) ? 8'hFF
                        : rf[bus.RsCont ? bus.instr_code[5:3] : bus.instr_code[2:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.regwrite === 1'b1) wq.push_back({bus.instr_code, bus.writedata});
        if (bus.in_ready === 1'b1 && (bus.regwrite === 1'b1 || prev_rw)) viol <= viol + 1;
        prev_rw <= (bus.regwrite === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic drive_load(input bit hold_start, output int lat);
        int c0, n;
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        c0 = cyc;
        done_at_start = done;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && error !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            if (bus.in_ready !== 1'b1) break;
            repeat (st[k]) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_data = d[k];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data = 8'($urandom);
        end
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        lat = cyc - c0;
    endtask

    task automatic check_load(input string name, input int lat, input int exp_lat);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL %s done/error: got %b/%b required 1/0", name, done, error);
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (wq.size() != 8) begin
            failures++;
            $display("FAIL %s write count: got %0d required 8", name, wq.size());
        end
        for (int k = 0; k < 8 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== {8'(k * 9), d[k]}) begin
                failures++;
                $display("FAIL %s write %0d: got %h required %h", name, k, wq[k], {8'(k * 9), d[k]});
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rf[k] !== d[k]) begin
                failures++;
                $display("FAIL %s reg %0d: got %h required %h", name, k, rf[k], d[k]);
            end
        end
        checks++;
        if ({busy, bus.RsCont, bus.in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL %s idle flags busy/RsCont/in_ready: got %b required 000", name, {busy, bus.RsCont, bus.in_ready});
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.regwrite, bus.RsCont, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset flags: got %b required 000000", {bus.in_ready, bus.regwrite, bus.RsCont, busy, done, error});
        end
        checks++;
        if (err_idx !== 3'd0) begin failures++; $display("FAIL reset err_idx: got %0d required 0", err_idx); end
        checks++;
        if (bus.instr_code !== 8'h00) begin failures++; $display("FAIL reset instr_code: got %h required 00", bus.instr_code); end
        checks++;
        if (bus.writedata !== 8'h00) begin failures++; $display("FAIL reset writedata: got %h required 00", bus.writedata); end
        checks++;
        if (wq.size() != 0) begin failures++; $display("FAIL reset writes: got %0d required 0", wq.size()); end
        start = 1'b0;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal;
        int lat;
        for (int k = 0; k < 8; k++) begin d[k] = 8'((k + 1) * 8'h11); st[k] = 0; end
        drive_load(1'b0, lat);
        check_load("nominal", lat, 24);
    endtask

    task automatic test_stall;
        int lat, tot;
        for (int r = 0; r < 3; r++) begin
            tot = 0;
            for (int k = 0; k < 8; k++) begin
                d[k] = 8'($urandom);
                st[k] = $urandom_range(0, 3);
                tot += st[k];
            end
            drive_load(1'b0, lat);
            check_load("stall", lat, 24 + tot);
        end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL in_ready during write/check: got %0d cycles required 0", viol); end
    endtask

    task automatic test_fault;
        int lat, n;
        for (int k = 0; k < 8; k++) begin d[k] = 8'((k + 1) * 8'h11); st[k] = 0; end
        fault_idx = 3'd5;
        fault_en = 1'b1;
        drive_load(1'b0, lat);
        checks++;
        if ({error, done, busy} !== 3'b100) begin failures++; $display("FAIL fault error/done/busy: got %b required 100", {error, done, busy}); end
        checks++;
        if (err_idx !== 3'd5) begin failures++; $display("FAIL fault err_idx: got %0d required 5", err_idx); end
        checks++;
        if (lat != 18) begin failures++; $display("FAIL fault latency: got %0d required 18", lat); end
        repeat (5) @(posedge clk);
        #1;
        n = wq.size();
        checks++;
        if (n != 6) begin failures++; $display("FAIL fault write count: got %0d required 6", n); end
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL fault error level: got %b required 1", error); end
        fault_en = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
        drive_load(1'b0, lat);
        check_load("restart", lat, 24);
        checks++;
        if (err_idx !== 3'd0) begin failures++; $display("FAIL restart err_idx: got %0d required 0", err_idx); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] old [8];
        int n, after;
        for (int k = 0; k < 8; k++) begin d[k] = 8'($urandom); old[k] = rf[k]; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            bus.in_valid = 1'b1;
            bus.in_data = d[k];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        checks++;
        if (bus.regwrite !== 1'b1 || bus.instr_code !== 8'h1B) begin
            failures++;
            $display("FAIL midreset write3: got regwrite=%b code=%h required 1/1b", bus.regwrite, bus.instr_code);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        after = wq.size();
        checks++;
        if ({bus.in_ready, bus.regwrite, bus.RsCont, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL midreset flags: got %b required 000000", {bus.in_ready, bus.regwrite, bus.RsCont, busy, done, error});
        end
        checks++;
        if (bus.instr_code !== 8'h00 || bus.writedata !== 8'h00 || err_idx !== 3'd0) begin
            failures++;
            $display("FAIL midreset fields: got code=%h wd=%h err_idx=%0d required 00/00/0", bus.instr_code, bus.writedata, err_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        checks++;
        if (wq.size() != after) begin failures++; $display("FAIL midreset late writes: got %0d required %0d", wq.size(), after); end
        for (int k = 0; k < 8; k++) begin
            if (k == 3) continue;
            checks++;
            if (rf[k] !== (k < 3 ? d[k] : old[k])) begin
                failures++;
                $display("FAIL midreset reg %0d: got %h required %h", k, rf[k], (k < 3 ? d[k] : old[k]));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy;
        int lat, tot;
        tot = 0;
        for (int k = 0; k < 8; k++) begin
            d[k] = 8'($urandom);
            st[k] = (k == 0 || k == 4) ? 2 : 0;
            tot += st[k];
        end
        drive_load(1'b1, lat);
        check_load("start_busy", lat, 24 + tot);
        for (int k = 0; k < 8; k++) begin d[k] = 8'($urandom); st[k] = 0; end
        drive_load(1'b0, lat);
        checks++;
        if (done_at_start !== 1'b0) begin failures++; $display("FAIL start in done: done got %b required 0 after start", done_at_start); end
        check_load("start_done", lat, 24);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) rf[k] = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_nominal();
        test_stall();
        test_fault();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
